// File: rtl/regfile_mp_if.sv
// ============================================================================
// Module   : regfile_mp_if
// Brief    : Read/write/reserve bundle between the datapath and regfile_mp.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_mp_if #(
  parameter int N   = 16,
  parameter int R   = 3,
  parameter int NRD = 2,
  parameter int NWR = 2
);
  logic [NRD*R-1:0] ra;
  logic [NRD*N-1:0] rd;
  logic [NRD-1:0]   rbusy;
  logic [NWR-1:0]   we;
  logic [NWR*R-1:0] wa;
  logic [NWR*N-1:0] wd;
  logic             rsv_en;
  logic [R-1:0]     rsv_addr;
  logic [R:0]       busy_cnt;

  modport master (
    output ra, we, wa, wd, rsv_en, rsv_addr,
    input  rd, rbusy, busy_cnt
  );

  modport slave (
    input  ra, we, wa, wd, rsv_en, rsv_addr,
    output rd, rbusy, busy_cnt
  );
endinterface

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port register file with zero register and busy scoreboard.
//            Optional macro REGFILE_BYPASS_EN enables write-first forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp #(
  parameter int N   = 16,
  parameter int R   = 3,
  parameter int NRD = 2,
  parameter int NWR = 2
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 1 << R;

  logic [N-1:0]     w_word [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;
  logic [DEPTH-1:0] w_written;
  logic [R:0]       r_busy_cnt;

  function automatic logic [R:0] popcount(input logic [DEPTH-1:0] v);
    logic [R:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{R{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Entry 0 is a constant; only entries 1..DEPTH-1 get flops.
  assign w_word[0] = '0;

  generate
    for (genvar i = 1; i < DEPTH; i++) begin : g_entry
      logic [N-1:0] r_data;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_data <= '0;
        end else begin
          for (int j = 0; j < NWR; j++) begin
            if (bus.we[j] && (bus.wa[j*R +: R] == R'(i))) begin
              r_data <= bus.wd[j*N +: N];
            end
          end
        end
      end
      assign w_word[i] = r_data;
    end
  endgenerate

  // Writes release first, then a reservation re-marks: new producer wins.
  always_comb begin
    w_written = '0;
    for (int j = 0; j < NWR; j++) begin
      if (bus.we[j]) begin
        w_written[bus.wa[j*R +: R]] = 1'b1;
      end
    end
    w_written[0] = 1'b0;
    w_busy_next = r_busy & ~w_written;
    if (bus.rsv_en) begin
      w_busy_next[bus.rsv_addr] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_busy_cnt <= popcount(w_busy_next);
    end
  end

  assign bus.busy_cnt = r_busy_cnt;

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [R-1:0] w_ra;
      logic [N-1:0] w_rd;
      logic         w_rb;
      assign w_ra = bus.ra[k*R +: R];
`ifdef REGFILE_BYPASS_EN
      always_comb begin
        w_rd = w_word[w_ra];
        w_rb = r_busy[w_ra];
        for (int j = 0; j < NWR; j++) begin
          if (bus.we[j] && (bus.wa[j*R +: R] == w_ra)) begin
            w_rd = bus.wd[j*N +: N];
          end
        end
        if (w_written[w_ra]) begin
          w_rb = w_busy_next[w_ra];
        end
        if (w_ra == '0) begin
          w_rd = '0;
          w_rb = 1'b0;
        end
      end
`else
      // Entry 0 reads zero and never busy without an explicit compare.
      assign w_rd = w_word[w_ra];
      assign w_rb = r_busy[w_ra];
`endif
      assign bus.rd[k*N +: N] = w_rd;
      assign bus.rbusy[k]     = w_rb;
    end
  endgenerate

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file: NRD asynchronous read ports, NWR synchronous write ports.
- Adds a hardwired zero register and a per-register busy scoreboard (reserve on issue, release on writeback).
- Sits between decode (reads, reserve) and writeback (writes) in the gigaHurt datapath.
- Successor to the fixed 2-read/1-write file; default widths match the existing 16-bit, 8-entry file.

Parameters:
- n, 16: data width in bits.
- r, 3: address width; depth = 2**r entries.
- NRD, 2: number of read ports (1..4).
- NWR, 2: number of write ports (1..2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- ra  input  NRD*r  read addresses; port k = ra[k*r +: r].
- rd  output  NRD*n  read data; port k = rd[k*n +: n].
- rbusy  output  NRD  busy bit of the register addressed by port k.
- we  input  NWR  write enable per write port.
- wa  input  NWR*r  write addresses; port j = wa[j*r +: r].
- wd  input  NWR*n  write data; port j = wd[j*n +: n].
- rsv_en  input  1  reserve request; marks rsv_addr busy.
- rsv_addr  input  r  register to reserve.
- busy_cnt  output  r+1  number of registers currently busy (registered).

Behaviour:
- Storage: 2**r x n flops plus a 2**r-bit busy vector. Entry 0 has no storage.
- Reset (synchronous, sampled at posedge clk):
  - all entries cleared to 0, busy vector cleared, busy_cnt = 0;
  - reset dominates every we and rsv_en in the same cycle.
- Read (combinational, zero latency):
  - rd[k] = mem[ra[k]]; ra[k] == 0 -> rd[k] = 0, rbusy[k] = 0.
  - Without REGFILE_BYPASS_EN, a write in cycle t is visible on rd after the posedge ending cycle t.
- Write (posedge clk):
  - we[j] && wa[j] != 0 -> mem[wa[j]] <= wd[j]; writes to 0 are discarded.
  - Two ports, same address, same cycle: the higher port index wins (port 1 over port 0).
- Scoreboard (posedge clk):
  - a write to address a clears busy[a];
  - rsv_en && rsv_addr != 0 sets busy[rsv_addr];
  - reserve and write to the same address in the same cycle: busy ends 1 (new producer wins), data is still written;
  - reserving an already-busy register leaves it 1 (no count change);
  - writing a non-busy register leaves busy unchanged at 0.
- busy_cnt:
  - registered population count of the busy vector after the update, so it is valid the cycle after the edge;
  - range 0..2**r-1, never counts entry 0.
- X-safety: on reset all outputs are defined, with rd = 0 for every address.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-first forwarding. If we[j] && wa[j] == ra[k] && ra[k] != 0 in the same cycle, rd[k] = wd[j]; the highest matching j wins. rbusy[k] shows the post-write value: 0 unless rsv_en targets the same address that cycle, then 1.
- Undefined: reads return pre-edge contents and the current busy bit only.

Test Plan:
- Reset: hold reset 2 cycles with we=2'b11, wa={3,3}, wd={16'hAAAA,16'h5555} -> after release, rd for all 8 addresses = 0, busy_cnt = 0.
- Write/read: write 16'h00F0 to reg 2 (port 0), 16'h0F00 to reg 5 (port 1) in one cycle; next cycle ra={5,2} -> rd = {16'h0F00,16'h00F0}. Write 16'hFFFF to reg 0 -> ra=0 reads 0.
- Write conflict: we=2'b11, wa={4,4}, wd={16'h1234,16'h5678}, i.e. port 1 = 16'h1234 -> reg 4 = 16'h1234.
- Scoreboard: reserve 3, then 6 on consecutive cycles -> busy_cnt 1 then 2, rbusy for ra=3 is 1. Write reg 3 -> busy_cnt 1. Reserve and write reg 6 in the same cycle -> stays busy, busy_cnt 1, reg 6 holds new data.
- Bypass:
  - with REGFILE_BYPASS_EN: write 16'hBEEF to reg 7 while ra[0]=7 -> rd[0] = 16'hBEEF in the same cycle;
  - without it: rd[0] shows the old value, then 16'hBEEF after the edge.
- Reset mid-operation: with regs 1..3 busy and written, assert reset alongside rsv_en=1, rsv_addr=1 -> all data 0, busy vector 0, busy_cnt 0 the next cycle.
